// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_dump_reader_pkg
// Brief  : Shared constants for the register-file dump reader: FSM state
//          encoding, frame layout and the header-byte helper.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_dump_reader_pkg;

    localparam int         c_stateW      = 3;

    localparam logic [2:0] c_stIdle      = 3'd0;
    localparam logic [2:0] c_stCapture   = 3'd1;
    localparam logic [2:0] c_stHdr       = 3'd2;
    localparam logic [2:0] c_stData      = 3'd3;
    localparam logic [2:0] c_stDone      = 3'd4;

    localparam logic [2:0] c_hdrTagDefault = 3'b101;

    // One header byte followed by the four word bytes, MSB first.
    localparam int         c_frameLen    = 5;
    localparam int         c_dataBytes   = c_frameLen - 1;

    function automatic logic [7:0] makeHeader(input logic [2:0] tag,
                                              input logic [4:0] idx);
        return {tag, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_word_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module : word_byte_serializer
// Brief  : Holds one captured word plus its index and emits the 5-byte frame
//          (header, then word MSB first) over a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module word_byte_serializer
    import regfile_dump_reader_pkg::*;
#(
    parameter logic [2:0] HDR_TAG = c_hdrTagDefault
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic [4:0]  i_idx,
    input  logic        i_txReady,
    output logic [7:0]  o_txData,
    output logic        o_txValid,
    output logic        o_lastByteAccepted
);

    localparam logic [1:0] c_lastCnt = 2'(c_dataBytes - 1);

    logic [31:0] r_word;
    logic [4:0]  r_idx;
    logic [1:0]  r_byteCnt;
    logic        r_inHdr;
    logic        r_valid;

    logic        w_accept;
    logic [7:0]  w_dataByte;

    assign w_accept = r_valid && i_txReady;

    always_comb begin
        w_dataByte = r_word[7:0];
        case (r_byteCnt)
            2'd0:    w_dataByte = r_word[31:24];
            2'd1:    w_dataByte = r_word[23:16];
            2'd2:    w_dataByte = r_word[15:8];
            default: w_dataByte = r_word[7:0];
        endcase
    end

    // Output byte is a pure decode of held registers, so it cannot move
    // while a byte is stalled waiting for the sink.
    assign o_txData           = r_inHdr ? makeHeader(HDR_TAG, r_idx) : w_dataByte;
    assign o_txValid          = r_valid;
    assign o_lastByteAccepted = w_accept && !r_inHdr && (r_byteCnt == c_lastCnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word    <= 32'd0;
            r_idx     <= 5'd0;
            r_byteCnt <= 2'd0;
            r_inHdr   <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_load) begin
            r_word    <= i_word;
            r_idx     <= i_idx;
            r_byteCnt <= 2'd0;
            r_inHdr   <= 1'b1;
            r_valid   <= 1'b1;
        end else if (w_accept) begin
            if (r_inHdr) begin
                r_inHdr   <= 1'b0;
                r_byteCnt <= 2'd0;
            end else begin
                r_byteCnt <= r_byteCnt + 2'd1;
                if (r_byteCnt == c_lastCnt) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module : regfile_dump_reader
// Brief  : Walks register-file entries FIRST_REG..LAST_REG through a read
//          port and streams each snapshot as a tagged byte frame.
// Rev    : 1.0  initial release
// ============================================================================
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int         FIRST_REG = 0,
    parameter int         LAST_REG  = 31,
    parameter logic [2:0] HDR_TAG   = c_hdrTagDefault
)(
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        start,
    output logic [4:0]  ctrl_readReg,
    input  logic [31:0] data_readReg,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] c_firstIdx = 5'(FIRST_REG);
    localparam logic [4:0] c_lastIdx  = 5'(LAST_REG);

    logic [c_stateW-1:0] r_state;
    logic [4:0]          r_idx;

    logic                w_load;
    logic                w_txValid;
    logic                w_hdrAccept;
    logic                w_lastByteAccepted;

    assign ctrl_readReg = r_idx;
    assign w_load       = (r_state == c_stCapture);
    assign w_hdrAccept  = (r_state == c_stHdr) && w_txValid && tx_ready;
    assign tx_valid     = w_txValid;
    assign busy         = (r_state != c_stIdle);
    assign done         = (r_state == c_stDone);

    word_byte_serializer #(
        .HDR_TAG            (HDR_TAG)
    ) u_serializer (
        .clk                (clock),
        .rst                (ctrl_reset),
        .i_load             (w_load),
        .i_word             (data_readReg),
        .i_idx              (r_idx),
        .i_txReady          (tx_ready),
        .o_txData           (tx_data),
        .o_txValid          (w_txValid),
        .o_lastByteAccepted (w_lastByteAccepted)
    );

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state <= c_stIdle;
            r_idx   <= c_firstIdx;
        end else begin
            case (r_state)
                c_stIdle: begin
                    if (start) begin
                        r_idx   <= c_firstIdx;
                        r_state <= c_stCapture;
                    end
                end
                c_stCapture: begin
                    r_state <= c_stHdr;
                end
                c_stHdr: begin
                    if (w_hdrAccept) begin
                        r_state <= c_stData;
                    end
                end
                c_stData: begin
                    // Index only advances below LAST_REG, so it never wraps.
                    if (w_lastByteAccepted) begin
                        if (r_idx == c_lastIdx) begin
                            r_state <= c_stDone;
                        end else begin
                            r_idx   <= r_idx + 5'd1;
                            r_state <= c_stCapture;
                        end
                    end
                end
                c_stDone: begin
                    r_state <= c_stIdle;
                end
                default: begin
                    r_state <= c_stIdle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_regfile_dump_reader
// Brief  : Directed self-checking bench for regfile_dump_reader using three
//          instances (full range, single register, range 9..12).
// Rev    : 1.0  initial release
// ============================================================================
module tb_regfile_dump_reader;

    logic        clk;
    logic        startV   [3];
    logic        resetV   [3];
    logic        readyV   [3];
    logic [4:0]  addrV    [3];
    logic [31:0] rdV      [3];
    logic [7:0]  txDataV  [3];
    logic        txValidV [3];
    logic        busyV    [3];
    logic        doneV    [3];

    logic [31:0] rf [32];
    logic [7:0]  bq [$];

    int checks   = 0;
    int failures = 0;

    int          doneCyc;
    int          doneCnt;
    logic        busyAfter;
    int          stallErr;

    assign rdV[0] = rf[addrV[0]];
    assign rdV[1] = rf[addrV[1]];
    assign rdV[2] = rf[addrV[2]];

    regfile_dump_reader u_full (
        .clock(clk), .ctrl_reset(resetV[0]), .start(startV[0]),
        .ctrl_readReg(addrV[0]), .data_readReg(rdV[0]),
        .tx_data(txDataV[0]), .tx_valid(txValidV[0]), .tx_ready(readyV[0]),
        .busy(busyV[0]), .done(doneV[0])
    );

    regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5)) u_single (
        .clock(clk), .ctrl_reset(resetV[1]), .start(startV[1]),
        .ctrl_readReg(addrV[1]), .data_readReg(rdV[1]),
        .tx_data(txDataV[1]), .tx_valid(txValidV[1]), .tx_ready(readyV[1]),
        .busy(busyV[1]), .done(doneV[1])
    );

    regfile_dump_reader #(.FIRST_REG(9), .LAST_REG(12)) u_range (
        .clock(clk), .ctrl_reset(resetV[2]), .start(startV[2]),
        .ctrl_readReg(addrV[2]), .data_readReg(rdV[2]),
        .tx_data(txDataV[2]), .tx_valid(txValidV[2]), .tx_ready(readyV[2]),
        .busy(busyV[2]), .done(doneV[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start a dump on instance sel (start high in cycle 0) and follow it to
    // one cycle past done, logging accepted bytes into bq. Cycle numbers
    // count clock cycles from the one in which start is sampled.
    task automatic runDump(input int sel, input bit toggle, input int pulseAt,
                           input int writeAt, input int writeIdx,
                           input logic [31:0] writeVal);
        logic       prevStall;
        logic [7:0] prevData;
        bq.delete();
        doneCyc   = -1;
        doneCnt   = 0;
        busyAfter = 1'bx;
        stallErr  = 0;
        prevStall = 1'b0;
        prevData  = 8'h00;
        readyV[sel] = 1'b1;
        startV[sel] = 1'b1;
        tick();
        startV[sel] = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            readyV[sel] = toggle ? ((cyc % 2) == 1) : 1'b1;
            startV[sel] = (cyc == pulseAt);
            if (cyc == writeAt) rf[writeIdx] = writeVal;
            if (prevStall && (txValidV[sel] !== 1'b1 || txDataV[sel] !== prevData))
                stallErr++;
            if (doneV[sel] === 1'b1) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (doneCyc >= 0 && cyc == doneCyc + 1) begin
                busyAfter = busyV[sel];
                break;
            end
            if (txValidV[sel] === 1'b1 && readyV[sel] === 1'b1)
                bq.push_back(txDataV[sel]);
            prevStall = (txValidV[sel] === 1'b1) && !readyV[sel];
            prevData  = txDataV[sel];
            tick();
        end
        startV[sel] = 1'b0;
        readyV[sel] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'(32'h01010101 * k);
        for (int i = 0; i < 3; i++) begin
            startV[i] = 1'b0;
            resetV[i] = 1'b1;
            readyV[i] = 1'b1;
        end

        // Reset state
        tick();
        tick();
        check("rst_valid",  {31'd0, txValidV[0]}, 32'd0);
        check("rst_data",   {24'd0, txDataV[0]},  32'd0);
        check("rst_busy",   {31'd0, busyV[0]},    32'd0);
        check("rst_done",   {31'd0, doneV[0]},    32'd0);
        check("rst_addr",   {27'd0, addrV[0]},    32'd0);
        check("rst_addr9",  {27'd0, addrV[2]},    32'd9);
        for (int i = 0; i < 3; i++) resetV[i] = 1'b0;
        tick();

        // Full dump, tx_ready held high
        runDump(0, 1'b0, 0, 0, 0, 32'd0);
        check("full_bytes",   bq.size(),  160);
        check("full_hdr0",    bq[0],      8'hA0);
        check("full_reg0b0",  bq[1],      8'h00);
        check("full_hdr3",    bq[15],     8'hA3);
        check("full_reg3b0",  bq[16],     8'h03);
        check("full_reg3b1",  bq[17],     8'h03);
        check("full_reg3b2",  bq[18],     8'h03);
        check("full_reg3b3",  bq[19],     8'h03);
        check("full_hdr31",   bq[155],    8'hBF);
        check("full_last",    bq[159],    8'h1F);
        check("full_donecyc", doneCyc,    193);
        check("full_donecnt", doneCnt,    1);
        check("full_busyoff", {31'd0, busyAfter}, 32'd0);

        // Second start pulse mid-dump must be ignored
        tick();
        runDump(0, 1'b0, 50, 0, 0, 32'd0);
        check("restart_bytes",   bq.size(), 160);
        check("restart_donecyc", doneCyc,   193);
        check("restart_donecnt", doneCnt,   1);

        // Backpressure on a single-register dump
        rf[5] = 32'hDEADBEEF;
        tick();
        runDump(1, 1'b1, 0, 0, 0, 32'd0);
        check("bp_bytes",   bq.size(), 5);
        check("bp_hdr",     bq[0],     8'hA5);
        check("bp_b0",      bq[1],     8'hDE);
        check("bp_b1",      bq[2],     8'hAD);
        check("bp_b2",      bq[3],     8'hBE);
        check("bp_b3",      bq[4],     8'hEF);
        check("bp_stable",  stallErr,  0);
        check("bp_donecnt", doneCnt,   1);
        check("bp_donecyc", doneCyc,   12);

        // Range 9..12 with reg 9 rewritten right after its capture
        rf[9] = 32'h00000010;
        tick();
        runDump(2, 1'b0, 0, 2, 9, 32'h00000020);
        check("rng_bytes",   bq.size(), 20);
        check("rng_hdr9",    bq[0],     8'hA9);
        check("rng_hdr10",   bq[5],     8'hAA);
        check("rng_hdr11",   bq[10],    8'hAB);
        check("rng_hdr12",   bq[15],    8'hAC);
        check("snap_b0",     bq[1],     8'h00);
        check("snap_b2",     bq[3],     8'h00);
        check("snap_b3",     bq[4],     8'h10);
        check("rng_reg10b3", bq[9],     8'h0A);
        check("rng_donecyc", doneCyc,   25);
        check("rng_donecnt", doneCnt,   1);

        // Reset during DATA byte 2 of reg 12 (cycle 23 of a 9..12 dump)
        rf[12] = 32'h11223344;
        tick();
        readyV[2] = 1'b1;
        startV[2] = 1'b1;
        tick();
        startV[2] = 1'b0;
        repeat (22) tick();
        check("mid_addr",  {27'd0, addrV[2]},    32'd12);
        check("mid_valid", {31'd0, txValidV[2]}, 32'd1);
        check("mid_byte2", {24'd0, txDataV[2]},  32'h33);
        resetV[2] = 1'b1;
        tick();
        resetV[2] = 1'b0;
        check("rstmid_valid", {31'd0, txValidV[2]}, 32'd0);
        check("rstmid_busy",  {31'd0, busyV[2]},    32'd0);
        check("rstmid_addr",  {27'd0, addrV[2]},    32'd9);
        check("rstmid_done",  {31'd0, doneV[2]},    32'd0);
        check("rstmid_data",  {24'd0, txDataV[2]},  32'd0);
        tick();
        check("rstmid_done2", {31'd0, doneV[2]},    32'd0);

        runDump(2, 1'b0, 0, 0, 0, 32'd0);
        check("redo_bytes",   bq.size(), 20);
        check("redo_hdr9",    bq[0],     8'hA9);
        check("redo_reg9b3",  bq[4],     8'h20);
        check("redo_reg12b0", bq[16],    8'h11);
        check("redo_reg12b1", bq[17],    8'h22);
        check("redo_reg12b2", bq[18],    8'h33);
        check("redo_reg12b3", bq[19],    8'h44);
        check("redo_donecyc", doneCyc,   25);
        check("redo_donecnt", doneCnt,   1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
